// File: rtl/dual_issue_queue_pkg.sv
// dual_issue_queue shared package: pipe-class prefix, register field
// positions, default sizes and the default-width queue entry type.
package dual_issue_queue_pkg;

  localparam int DEPTH_DEF   = 4;
  localparam int PC_W_DEF    = 10;
  localparam int INSTR_W_DEF = 32;

  localparam logic [2:0] ODD_PREFIX = 3'b001;
  localparam int OP_LSB = 0;
  localparam int OP_W   = 3;

  localparam int REG_W  = 7;
  localparam int RT_LSB = 25;
  localparam int RA_LSB = 18;
  localparam int RB_LSB = 11;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
    logic                   odd;
  } entry_t;

endpackage

// File: rtl/dual_issue_queue_if.sv
// dual_issue_queue bus: fetch pair in, issue slots out, stall/flush.
// master = fetch/control side, slave = the queue.
interface dual_issue_queue_if
  import dual_issue_queue_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);
  logic               in_valid;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr1;
  logic [INSTR_W-1:0] in_instr2;
  logic               flush;
  logic               ex_stall;
  logic               stall_out;
  logic               issue0_valid;
  logic [INSTR_W-1:0] issue0_instr;
  logic [PC_W-1:0]    issue0_pc;
  logic               issue0_odd;
  logic               issue1_valid;
  logic [INSTR_W-1:0] issue1_instr;
  logic [PC_W-1:0]    issue1_pc;
  logic [31:0]        stat_dual_cnt;
  logic [31:0]        stat_single_cnt;

  modport master (
    output in_valid, in_pc, in_instr1, in_instr2,
    output flush, ex_stall,
    input  stall_out,
    input  issue0_valid, issue0_instr, issue0_pc, issue0_odd,
    input  issue1_valid, issue1_instr, issue1_pc,
    input  stat_dual_cnt, stat_single_cnt
  );

  modport slave (
    input  in_valid, in_pc, in_instr1, in_instr2,
    input  flush, ex_stall,
    output stall_out,
    output issue0_valid, issue0_instr, issue0_pc, issue0_odd,
    output issue1_valid, issue1_instr, issue1_pc,
    output stat_dual_cnt, stat_single_cnt
  );
endinterface

// File: rtl/dual_issue_queue_pipe_classifier.sv
// pipe_classifier: odd/even pipe decode of an instruction pair and
// whether b reads the register a writes (rt vs ra/rb).
module pipe_classifier
  import dual_issue_queue_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic [INSTR_W-1:0] instr_a,
  input  logic [INSTR_W-1:0] instr_b,
  output logic               odd_a,
  output logic               odd_b,
  output logic               dep
);
  logic [REG_W-1:0] rt_a, ra_b, rb_b;

  assign rt_a = instr_a[RT_LSB +: REG_W];
  assign ra_b = instr_b[RA_LSB +: REG_W];
  assign rb_b = instr_b[RB_LSB +: REG_W];

  assign odd_a = instr_a[OP_LSB +: OP_W] == ODD_PREFIX;
  assign odd_b = instr_b[OP_LSB +: OP_W] == ODD_PREFIX;
  assign dep   = (rt_a == ra_b) || (rt_a == rb_b);
endmodule

// File: rtl/dual_issue_queue.sv
// dual_issue_queue: fetch-pair queue with in-order dual issue.
// Optional ISSUE_STATS_EN builds saturating dual/single issue counters.
module dual_issue_queue
  import dual_issue_queue_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input logic              clk,
  input logic              rst,
  dual_issue_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               odd;
  } q_entry_t;

  q_entry_t         q [DEPTH];
  q_entry_t         e0, e1;
  logic [AW-1:0]    head, tail, head1, tail1;
  logic [CW-1:0]    count;
  logic             accept, can_dual, dep;
  logic             odd1, odd2;
  logic             unused_dep_in, unused_odd_a, unused_odd_b;
  logic [1:0]       n_iss;

  assign head1 = head + AW'(1);
  assign tail1 = tail + AW'(1);
  assign e0    = q[head];
  assign e1    = q[head1];

  assign bus.stall_out = count > CW'(DEPTH - 2);
  assign accept = bus.in_valid && !bus.stall_out && !bus.flush;

  pipe_classifier #(.INSTR_W(INSTR_W)) u_cls_in (
    .instr_a (bus.in_instr1),
    .instr_b (bus.in_instr2),
    .odd_a   (odd1),
    .odd_b   (odd2),
    .dep     (unused_dep_in)
  );

  pipe_classifier #(.INSTR_W(INSTR_W)) u_cls_iss (
    .instr_a (e0.instr),
    .instr_b (e1.instr),
    .odd_a   (unused_odd_a),
    .odd_b   (unused_odd_b),
    .dep     (dep)
  );

  assign can_dual = (count >= CW'(2)) && !e0.odd && e1.odd && !dep;

  // Number of entries leaving the queue this cycle.
  always_comb begin
    n_iss = 2'd0;
    if (!bus.ex_stall && !bus.flush && count != '0)
      n_iss = can_dual ? 2'd2 : 2'd1;
  end

  // Queue storage: write the accepted pair at tail, tail+1.
  always_ff @(posedge clk) begin
    if (accept) begin
      q[tail]  <= '{pc: bus.in_pc, instr: bus.in_instr1, odd: odd1};
      q[tail1] <= '{pc: bus.in_pc + PC_W'(1),
                    instr: bus.in_instr2, odd: odd2};
    end
  end

  // Pointers, occupancy and registered issue slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      bus.issue0_valid  <= 1'b0;
      bus.issue0_instr  <= '0;
      bus.issue0_pc     <= '0;
      bus.issue0_odd    <= 1'b0;
      bus.issue1_valid  <= 1'b0;
      bus.issue1_instr  <= '0;
      bus.issue1_pc     <= '0;
    end else if (bus.flush) begin
      count             <= '0;
      head              <= tail;
      bus.issue0_valid  <= 1'b0;
      bus.issue1_valid  <= 1'b0;
    end else begin
      if (accept)
        tail <= tail + AW'(2);
      head  <= head + AW'(n_iss);
      count <= count + (accept ? CW'(2) : CW'(0)) - CW'(n_iss);
      if (!bus.ex_stall) begin
        bus.issue0_valid <= n_iss != 2'd0;
        bus.issue1_valid <= n_iss == 2'd2;
        bus.issue0_instr <= e0.instr;
        bus.issue0_pc    <= e0.pc;
        bus.issue0_odd   <= e0.odd;
        bus.issue1_instr <= e1.instr;
        bus.issue1_pc    <= e1.pc;
      end
    end
  end

`ifdef ISSUE_STATS_EN
  // Saturating issue-width counters; cleared by reset only.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.stat_dual_cnt   <= '0;
      bus.stat_single_cnt <= '0;
    end else begin
      if (n_iss == 2'd2 && bus.stat_dual_cnt != '1)
        bus.stat_dual_cnt <= bus.stat_dual_cnt + 32'd1;
      if (n_iss == 2'd1 && bus.stat_single_cnt != '1)
        bus.stat_single_cnt <= bus.stat_single_cnt + 32'd1;
    end
  end
`else
  assign bus.stat_dual_cnt   = '0;
  assign bus.stat_single_cnt = '0;
`endif

endmodule

// File: tb/tb_dual_issue_queue.sv
// tb_dual_issue_queue: directed pairs, expected issues queued up front,
// a monitor pops and compares each issue the DUT makes.
module tb_dual_issue_queue;
  import dual_issue_queue_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  dual_issue_queue_if bus ();

  dual_issue_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    entry_t s0;
    logic   v1;
    entry_t s1;
  } exp_t;

  exp_t sbq[$];

`ifdef ISSUE_STATS_EN
  localparam int EXP_DUAL   = 1;
  localparam int EXP_SINGLE = 35;
`else
  localparam int EXP_DUAL   = 0;
  localparam int EXP_SINGLE = 0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mk(input logic [2:0] op,
      input logic [6:0] rt, input logic [6:0] ra, input logic [6:0] rb);
    return {rt, ra, rb, 8'h00, op};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic exp1(input logic [9:0] pc, input logic [31:0] ins,
                      input logic odd);
    exp_t e;
    e.s0 = '{pc: pc, instr: ins, odd: odd};
    e.v1 = 1'b0;
    e.s1 = '0;
    sbq.push_back(e);
  endtask

  task automatic exp2(input logic [9:0] pc, input logic [31:0] a,
                      input logic [31:0] b);
    exp_t e;
    e.s0 = '{pc: pc, instr: a, odd: 1'b0};
    e.v1 = 1'b1;
    e.s1 = '{pc: pc + 10'd1, instr: b, odd: 1'b1};
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [9:0] pc, input logic [31:0] a,
                       input logic [31:0] b);
    bus.in_valid  = 1'b1;
    bus.in_pc     = pc;
    bus.in_instr1 = a;
    bus.in_instr2 = b;
  endtask

  // Hold the pair until the queue takes it (bounded wait).
  task automatic send_pair(input logic [9:0] pc, input logic [31:0] a,
                           input logic [31:0] b);
    int n;
    @(negedge clk);
    drive(pc, a, b);
    n = 0;
    while (bus.stall_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n >= 200), 32'd0);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(sbq.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  logic   mon_adv;
  exp_t   mon_e;
  entry_t mon_got;

  // Monitor: every edge that may issue is checked against the queue.
  always @(posedge clk) begin
    mon_adv = !bus.ex_stall && !bus.flush && !rst;
    #1;
    if (mon_adv && bus.issue0_valid) begin
      n_chk++;
      mon_got = '{pc: bus.issue0_pc, instr: bus.issue0_instr,
                  odd: bus.issue0_odd};
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_issue pc0=%h v1=%b",
                 bus.issue0_pc, bus.issue1_valid);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_got !== mon_e.s0 || bus.issue1_valid !== mon_e.v1 ||
            (mon_e.v1 && (bus.issue1_pc !== mon_e.s1.pc ||
                          bus.issue1_instr !== mon_e.s1.instr)))
          begin
          n_fail++;
          $display("FAIL issue got pc0=%h i0=%h o0=%b v1=%b pc1=%h i1=%h exp pc0=%h i0=%h o0=%b v1=%b pc1=%h i1=%h",
                   bus.issue0_pc, bus.issue0_instr, bus.issue0_odd,
                   bus.issue1_valid, bus.issue1_pc, bus.issue1_instr,
                   mon_e.s0.pc, mon_e.s0.instr, mon_e.s0.odd,
                   mon_e.v1, mon_e.s1.pc, mon_e.s1.instr);
        end
      end
    end else if (!rst && bus.issue1_valid && !bus.issue0_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL slot1_without_slot0 pc1=%h", bus.issue1_pc);
    end
  end

  initial begin
    logic [31:0] a, b;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_pc = '0;
    bus.in_instr1 = '0;
    bus.in_instr2 = '0;
    bus.flush = 1'b0;
    bus.ex_stall = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_v0", 32'(bus.issue0_valid), 32'd0);
    chk("rst_v1", 32'(bus.issue1_valid), 32'd0);
    chk("rst_pc0", 32'(bus.issue0_pc), 32'd0);
    chk("rst_i0", bus.issue0_instr, 32'd0);
    chk("rst_odd0", 32'(bus.issue0_odd), 32'd0);
    chk("rst_pc1", 32'(bus.issue1_pc), 32'd0);
    chk("rst_i1", bus.issue1_instr, 32'd0);
    chk("rst_stall", 32'(bus.stall_out), 32'd0);
    chk("rst_dual", bus.stat_dual_cnt, 32'd0);
    chk("rst_single", bus.stat_single_cnt, 32'd0);
    rst = 1'b0;

    // Even add + independent odd load: dual issue
    a = mk(3'b000, 7'd5, 7'd1, 7'd2);
    b = mk(3'b001, 7'd3, 7'd7, 7'd8);
    exp2(10'h010, a, b);
    send_pair(10'h010, a, b);
    idle();
    wait_drain("drain_dual");
    chk("stat_dual_after_pair", bus.stat_dual_cnt, 32'(EXP_DUAL));

    // ra dependency: two single issues
    a = mk(3'b000, 7'd5, 7'd1, 7'd2);
    b = mk(3'b001, 7'd3, 7'd5, 7'd8);
    exp1(10'h010, a, 1'b0);
    exp1(10'h011, b, 1'b1);
    send_pair(10'h010, a, b);
    idle();
    wait_drain("drain_ra_dep");

    // rb dependency: two single issues
    a = mk(3'b000, 7'd6, 7'd1, 7'd2);
    b = mk(3'b001, 7'd3, 7'd4, 7'd6);
    exp1(10'h020, a, 1'b0);
    exp1(10'h021, b, 1'b1);
    send_pair(10'h020, a, b);
    idle();
    wait_drain("drain_rb_dep");

    // PC wraps inside a pair
    a = mk(3'b000, 7'd20, 7'd21, 7'd22);
    b = mk(3'b000, 7'd23, 7'd24, 7'd25);
    exp1(10'h3FF, a, 1'b0);
    exp1(10'h000, b, 1'b0);
    send_pair(10'h3FF, a, b);
    idle();
    wait_drain("drain_pc_wrap");

    // ex_stall backpressure: third pair held until count <= 2
    for (int k = 0; k < 6; k++)
      exp1(10'h100 + 10'(k), mk(3'b000, 7'(40 + k), 7'd0, 7'd0), 1'b0);
    @(negedge clk);
    bus.ex_stall = 1'b1;
    send_pair(10'h100, mk(3'b000, 7'd40, 7'd0, 7'd0),
              mk(3'b000, 7'd41, 7'd0, 7'd0));
    send_pair(10'h102, mk(3'b000, 7'd42, 7'd0, 7'd0),
              mk(3'b000, 7'd43, 7'd0, 7'd0));
    @(negedge clk);
    drive(10'h104, mk(3'b000, 7'd44, 7'd0, 7'd0),
          mk(3'b000, 7'd45, 7'd0, 7'd0));
    chk("stall_full", 32'(bus.stall_out), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("stall_held", 32'(bus.stall_out), 32'd1);
      chk("no_issue_held", 32'(bus.issue0_valid), 32'd0);
    end
    bus.ex_stall = 1'b0;
    send_pair(10'h104, mk(3'b000, 7'd44, 7'd0, 7'd0),
              mk(3'b000, 7'd45, 7'd0, 7'd0));
    idle();
    wait_drain("drain_backpressure");

    // Flush with three queued and a pair presented
    @(negedge clk);
    bus.ex_stall = 1'b1;
    send_pair(10'h200, mk(3'b000, 7'd50, 7'd0, 7'd0),
              mk(3'b000, 7'd51, 7'd0, 7'd0));
    send_pair(10'h202, mk(3'b000, 7'd52, 7'd0, 7'd0),
              mk(3'b000, 7'd53, 7'd0, 7'd0));
    exp1(10'h200, mk(3'b000, 7'd50, 7'd0, 7'd0), 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.ex_stall = 1'b0;
    @(negedge clk);
    bus.ex_stall = 1'b1;
    chk("count3_stall", 32'(bus.stall_out), 32'd1);
    bus.flush = 1'b1;
    drive(10'h204, mk(3'b000, 7'd54, 7'd0, 7'd0),
          mk(3'b000, 7'd55, 7'd0, 7'd0));
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_v0", 32'(bus.issue0_valid), 32'd0);
    chk("flush_v1", 32'(bus.issue1_valid), 32'd0);
    chk("flush_stall", 32'(bus.stall_out), 32'd0);
    bus.ex_stall = 1'b0;
    repeat (5) @(negedge clk);
    chk("flush_sb_empty", 32'(sbq.size()), 32'd0);
    a = mk(3'b000, 7'd60, 7'd0, 7'd0);
    b = mk(3'b000, 7'd61, 7'd0, 7'd0);
    exp1(10'h300, a, 1'b0);
    exp1(10'h301, b, 1'b0);
    send_pair(10'h300, a, b);
    idle();
    wait_drain("drain_after_flush");

    // Ten (odd, even) pairs across the pointer wrap, all single issue
    for (int k = 0; k < 10; k++) begin
      exp1(10'h040 + 10'(2 * k), mk(3'b001, 7'd1, 7'd9, 7'(k)), 1'b1);
      exp1(10'h041 + 10'(2 * k), mk(3'b000, 7'd9, 7'(k), 7'd4), 1'b0);
    end
    for (int k = 0; k < 10; k++)
      send_pair(10'h040 + 10'(2 * k), mk(3'b001, 7'd1, 7'd9, 7'(k)),
                mk(3'b000, 7'd9, 7'(k), 7'd4));
    idle();
    wait_drain("drain_wrap");

    chk("stat_dual_final", bus.stat_dual_cnt, 32'(EXP_DUAL));
    chk("stat_single_final", bus.stat_single_cnt, 32'(EXP_SINGLE));
    chk("final_stall", 32'(bus.stall_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_issue_queue.md
Name: dual_issue_queue

Overview:
- Sits directly downstream of the instruction fetch stage.
- Accepts the fetched instruction pair (PC, PC+1) into a small circular queue and classifies each entry as even-pipe or odd-pipe.
- Issues up to two instructions per cycle, in order, to the decode/register-fetch stage.
- Produces the stall that freezes fetch when the queue cannot take another pair; flushes on a taken branch.

Parameters:
DEPTH, 4, queue entries; power of two, >= 4
PC_W, 10, instruction address width
INSTR_W, 32, instruction width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  fetch pair valid
in_pc  in  PC_W  PC of in_instr1; in_instr2 is at in_pc+1 (mod 2^PC_W)
in_instr1  in  INSTR_W  first fetched instruction
in_instr2  in  INSTR_W  second fetched instruction
flush  in  1  branch taken; discard all queued and in-flight instructions
ex_stall  in  1  downstream cannot accept; hold issue outputs
stall_out  out  1  to fetch stage stall; pair not accepted this cycle
issue0_valid  out  1  slot 0 valid
issue0_instr  out  INSTR_W  slot 0 instruction
issue0_pc  out  PC_W  slot 0 PC
issue0_odd  out  1  slot 0 pipe class (1 = odd)
issue1_valid  out  1  slot 1 valid (only if issue0_valid)
issue1_instr  out  INSTR_W  slot 1 instruction
issue1_pc  out  PC_W  slot 1 PC
stat_dual_cnt  out  32  dual-issue cycle count (see Optional Feature)
stat_single_cnt  out  32  single-issue cycle count

Behaviour:
- Reset is synchronous and active-high; one clock.
- On rst: count=0, head/tail pointers=0, all issue outputs and stat counters = 0.
- Queue entry contents: {pc, instr, odd}.
- Classification: odd = 1 when instr bits 0:2 == ODD_PREFIX (3'b001); otherwise even. Computed at enqueue.
- stall_out = (count > DEPTH-2), from the registered count only.
  - It does not credit same-cycle issue; this is intentionally conservative.
- Accept = in_valid && !stall_out && !flush.
  - Writes instr1 at tail and instr2 at tail+1 (pointers mod DEPTH).
  - tail += 2.
- Issue decision, evaluated each cycle when !ex_stall && !flush, from the registered queue state:
  - count==0: issue nothing.
  - count>=1: head goes to slot 0.
  - Slot 1 takes head+1 only when all of the following hold:
    - count>=2
    - head is even-pipe and head+1 is odd-pipe
    - head rt (bits 25:31) differs from both head+1 ra (bits 18:24) and head+1 rb (bits 11:17)
  - head advances by the number issued.
- Issue output registers update at the clock edge. An enqueued pair is therefore visible on issue outputs one edge after acceptance (minimum queue latency 1 cycle).
- ex_stall=1: issue registers hold their values, no dequeue; enqueue still allowed if stall_out=0.
- When !ex_stall and nothing is issued, the valids go 0 at the edge.
- Count update: count_next = count + 2*accept - issued_count. Range 0..DEPTH, never exceeded.
- Flush has priority over all other activity. At the edge:
  - count=0, head=tail.
  - issue0_valid=issue1_valid=0.
  - Any pair presented that cycle is dropped.
- Flush together with ex_stall: flush wins.
- Reset during any operation: identical to the power-on reset state at that edge.
- Pointer wrap-around from DEPTH-1 to 0 is transparent. A pair may straddle the wrap.

Optional Feature:
- Macro ISSUE_STATS_EN.
- Defined: two 32-bit saturating counters, each reset by rst only (not flush).
  - stat_dual_cnt increments on each edge where two instructions issue.
  - stat_single_cnt increments on each edge where exactly one issues.
- Not defined: counters are not built; stat outputs are tied to 0. Ports remain so the interface is unchanged.

Decomposition:
- Shared package holds: ODD_PREFIX, register-field bit positions (RT, RA, RB), the queue entry struct/typedef, and DEPTH's default.
- One sub-module is natural: pipe_classifier.
  - Combinational: odd-class decode plus the rt-vs-ra/rb dependency compare.
  - Instantiated once per candidate pair.

Test Plan:
- rst=1 for 2 cycles -> all issue outputs 0, stall_out=0, counters 0.
- Pair pc=0x010: instr1 = even add (bits0:2=000, rt=5); instr2 = odd load (bits0:2=001, ra=7, rb=8) -> next edge issue0_pc=0x010, issue1_valid=1, issue1_pc=0x011; stat_dual_cnt=1 (with ISSUE_STATS_EN).
- Same pair but instr2 ra=5 -> edge 1 issues slot 0 only; edge 2 issues pc=0x011 in slot 0.
- ex_stall held high while 3 pairs presented -> after 2 pairs, count=4 and stall_out=1; third pair held. Release ex_stall -> queue drains in order, third pair accepted once count<=2.
- Flush asserted with count=3 and a valid pair presented -> next edge count=0, valids 0, pair not enqueued.
- Pointer wrap: 10 consecutive pairs of (odd, even) instructions -> strictly in-order single issue, PCs contiguous; no loss across the DEPTH-1 -> 0 wrap.
